// File: rtl/hazard_detection_unit_if.sv
// Hazard unit bus: ID/EX/MEM hazard inputs in, pipeline controls out.
// The pipeline side drives the master modport; the hazard unit is the slave.
interface hazard_detection_unit_if;
    // ID-stage sources
    logic [4:0]  id_rs_i;
    logic [4:0]  id_rt_i;
    logic        id_use_rs_i;
    logic        id_use_rt_i;
    logic        id_branch_i;
    logic        branch_taken_i;
    // EX-stage destination
    logic        ex_mem_read_i;
    logic        ex_reg_write_i;
    logic [4:0]  ex_rd_i;
    // MEM-stage destination and memory busy
    logic        mem_mem_read_i;
    logic [4:0]  mem_rd_i;
    logic        mem_stall_i;
    // Pipeline controls
    logic        pc_write_o;
    logic        if_id_write_o;
    logic        id_ex_bubble_o;
    logic        if_id_flush_o;
    logic        freeze_o;
    logic        timeout_o;
    logic [15:0] stall_cnt_o;

    modport master (
        output id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
        output id_branch_i, branch_taken_i,
        output ex_mem_read_i, ex_reg_write_i, ex_rd_i,
        output mem_mem_read_i, mem_rd_i, mem_stall_i,
        input  pc_write_o, if_id_write_o, id_ex_bubble_o,
        input  if_id_flush_o, freeze_o, timeout_o, stall_cnt_o
    );

    modport slave (
        input  id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
        input  id_branch_i, branch_taken_i,
        input  ex_mem_read_i, ex_reg_write_i, ex_rd_i,
        input  mem_mem_read_i, mem_rd_i, mem_stall_i,
        output pc_write_o, if_id_write_o, id_ex_bubble_o,
        output if_id_flush_o, freeze_o, timeout_o, stall_cnt_o
    );
endinterface

// File: rtl/hazard_detection_unit.sv
// Stall/flush controller: load-use and ID-branch stalls, memory freeze,
// freeze watchdog and saturating stall-cycle counter.
module hazard_detection_unit #(
    parameter int unsigned FREEZE_TIMEOUT = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    hazard_detection_unit_if.slave bus
);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_FREEZE = 2'd1;
    localparam logic [1:0] S_ERROR  = 2'd2;

    localparam bit          LP_WD_EN = (FREEZE_TIMEOUT != 0);
    localparam int unsigned LP_LAST_I =
        (FREEZE_TIMEOUT == 0) ? 0 : FREEZE_TIMEOUT - 1;
    localparam logic [7:0]  LP_LAST = LP_LAST_I[7:0];

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [7:0]  r_freeze_cnt;
    logic        r_timeout;
    logic [15:0] r_stall_cnt;

    logic w_ex_rs;
    logic w_ex_rt;
    logic w_mem_rs;
    logic w_mem_rt;
    logic w_ex_match;
    logic w_mem_match;
    logic w_load_use;
    logic w_br_haz;
    logic w_data_stall;
    logic w_expire;
    logic w_pc_write;
    logic w_if_id_write;
    logic w_bubble;
    logic w_flush;
    logic w_freeze;

    // Source/destination match; $0 and unused fields never match
    always_comb begin
        w_ex_rs  = bus.id_use_rs_i && (bus.ex_rd_i != 5'd0)
                   && (bus.ex_rd_i == bus.id_rs_i);
        w_ex_rt  = bus.id_use_rt_i && (bus.ex_rd_i != 5'd0)
                   && (bus.ex_rd_i == bus.id_rt_i);
        w_mem_rs = bus.id_use_rs_i && (bus.mem_rd_i != 5'd0)
                   && (bus.mem_rd_i == bus.id_rs_i);
        w_mem_rt = bus.id_use_rt_i && (bus.mem_rd_i != 5'd0)
                   && (bus.mem_rd_i == bus.id_rt_i);
        w_ex_match  = w_ex_rs || w_ex_rt;
        w_mem_match = w_mem_rs || w_mem_rt;
        w_load_use  = bus.ex_mem_read_i && w_ex_match;
        w_br_haz    = bus.id_branch_i
                      && ((bus.ex_reg_write_i && w_ex_match)
                          || (bus.mem_mem_read_i && w_mem_match));
        w_data_stall = w_load_use || w_br_haz;
    end

    // Watchdog fires on the busy edge that would reach FREEZE_TIMEOUT
    always_comb begin
        w_expire = LP_WD_EN && bus.mem_stall_i
                   && (r_freeze_cnt == LP_LAST)
                   && (r_state != S_ERROR);
    end

    // Next-state logic; expiry may hit from RUN when the timeout is 1
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_RUN: begin
                if (w_expire)
                    w_state_nxt = S_ERROR;
                else if (bus.mem_stall_i)
                    w_state_nxt = S_FREEZE;
            end
            S_FREEZE: begin
                if (w_expire)
                    w_state_nxt = S_ERROR;
                else if (!bus.mem_stall_i)
                    w_state_nxt = S_RUN;
            end
            S_ERROR: w_state_nxt = S_ERROR;
            default: w_state_nxt = S_RUN;
        endcase
    end

    // Control decode, highest priority first
    always_comb begin
        w_pc_write    = 1'b1;
        w_if_id_write = 1'b1;
        w_bubble      = 1'b0;
        w_flush       = 1'b0;
        w_freeze      = 1'b0;
        if (rst_i) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_bubble      = 1'b1;
        end else if (r_state == S_ERROR || bus.mem_stall_i) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_freeze      = 1'b1;
        end else if (w_data_stall) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_bubble      = 1'b1;
        end else if (bus.branch_taken_i) begin
            w_flush = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_state <= S_RUN;
        else
            r_state <= w_state_nxt;
    end

    // Consecutive busy-cycle counter, held at its ceiling
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_freeze_cnt <= 8'd0;
        else if (!bus.mem_stall_i)
            r_freeze_cnt <= 8'd0;
        else if (r_freeze_cnt != 8'hFF)
            r_freeze_cnt <= r_freeze_cnt + 8'd1;
    end

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_timeout <= 1'b0;
        else if (w_expire)
            r_timeout <= 1'b1;
    end

    // Saturating count of cycles with the PC held
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_stall_cnt <= 16'd0;
        else if (!w_pc_write && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign bus.pc_write_o     = w_pc_write;
    assign bus.if_id_write_o  = w_if_id_write;
    assign bus.id_ex_bubble_o = w_bubble;
    assign bus.if_id_flush_o  = w_flush;
    assign bus.freeze_o       = w_freeze;
    assign bus.timeout_o      = r_timeout;
    assign bus.stall_cnt_o    = r_stall_cnt;

endmodule
